ahb_arbiter: RTL
================

# ahb_arbiter

Round-robin bus arbiter for multi-manager AHB systems. It decides which manager drives the shared address/control bus that feeds the decoder and the subordinates. It tracks address-phase and data-phase ownership so the interconnect mux selects the correct manager's signals. It holds the bus through locked sequences and bursts, and bounds how long one manager can hold the bus while others wait.

## Interface

Parameters:
- NumManagers, 4, number of requesting managers (2..16)
- DefaultManager, 0, manager parked on the bus when nobody requests
- MaxHold, 4, max consecutive arbitration points one manager may win while others request (>=1)
- IdWidth = $clog2(NumManagers), derived

Ports:
- clk  in  1  bus clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req  in  NumManagers  per-manager bus request (HBUSREQ)
- lock  in  NumManagers  per-manager locked-transfer request (HLOCK)
- trans  in  2  HTRANS currently on the muxed address bus (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
- ready  in  1  muxed HREADY from the subordinate side
- grant  out  NumManagers  one-hot grant (HGRANT), registered
- addrOwner  out  IdWidth  manager owning the current address phase (HMASTER), registered
- dataOwner  out  IdWidth  manager owning the current data phase, registered
- locked  out  1  current address phase belongs to a locked sequence (HMASTLOCK), registered

## Operation

- Registered state: grantIdx, addrOwner, dataOwner, locked, holdCnt (width to hold MaxHold-1), state.
- States:
  - PARK: grant on DefaultManager, no req seen.
  - OWNED: a requesting manager holds grant.
  - LOCKED: the owner asserted lock; arbitration is frozen.
- Ownership pipeline, only on cycles with ready=1:
  - addrOwner <= grantIdx
  - dataOwner <= addrOwner
  - locked <= lock[grantIdx]
  - With ready=0 all three hold.
- Arbitration point: ready=1 AND grantIdx==addrOwner (handover complete) AND trans ∈ {IDLE, NONSEQ} AND lock[addrOwner]=0.
  - No point is taken during SEQ/BUSY, during ready=0, or in LOCKED. Grant and holdCnt hold.
- Decision at an arbitration point:
  - No req bit set: grant DefaultManager, holdCnt=0, state PARK.
  - req[grantIdx]=1 and (holdCnt < MaxHold-1 or no other req bit set): keep grant, holdCnt saturating +1, state OWNED.
  - Otherwise: grant the first set req bit scanning grantIdx+1, grantIdx+2, … modulo NumManagers (wrap-around), excluding grantIdx. Then holdCnt=0, state OWNED.
- LOCKED entry: in OWNED, ready=1, addrOwner==grantIdx, lock[addrOwner]=1 and trans≠IDLE.
- LOCKED exit: at the first ready=1 cycle with lock[addrOwner]=0 and trans ∈ {IDLE, NONSEQ}. That cycle is an arbitration point.
- Requests from non-granted managers never change grant outside arbitration points.
- grant is always exactly one-hot, never all-zero.

## Timing

- Reset values: grant=one-hot(DefaultManager), addrOwner=dataOwner=DefaultManager, locked=0, holdCnt=0, state PARK.
- Grant latency: req rising at cycle t, with t an arbitration point, gives grant at t+1.
  - The manager's first address phase is in the cycle after grant with ready=1, so addrOwner updates one ready-edge after grant.
  - dataOwner follows addrOwner one ready-edge later.
- Wait states: ready=0 freezes grant, addrOwner, dataOwner, locked, holdCnt and state.
- Simultaneous requests: round-robin order from the current owner. With owner 1 and req=4'b1101, the next grant is manager 2; with req=4'b1001 it is manager 3.
- The owner dropping req mid-burst (SEQ) does not move grant until the next IDLE/NONSEQ point.
- Reset asserted mid-transfer returns every output to its reset value asynchronously. The first arbitration after release starts from DefaultManager.

## Test plan

NumManagers=4, DefaultManager=0, MaxHold=4 throughout.

- Idle after reset, req=0, trans=IDLE, ready=1 for 10 cycles -> grant=4'b0001, addrOwner=dataOwner=0, locked=0 every cycle.
- req=4'b0100 at cycle 2, trans=IDLE -> grant=4'b0100 at cycle 3, addrOwner=2 at cycle 4, dataOwner=2 at cycle 5.
- Manager 1 owns and runs NONSEQ,SEQ,SEQ,SEQ; req=4'b1010 throughout -> grant stays 4'b0010 through the SEQ beats. It switches to 4'b1000 only after the fourth won arbitration point (MaxHold).
- Manager 3 asserts lock with NONSEQ/SEQ/IDLE cycles for 8 cycles while req=4'b1111 -> grant=4'b1000, locked=1 throughout. Grant moves to 4'b0001 (wrap-around) at the first IDLE with lock low.
- ready=0 held 3 cycles during a handover from 0 to 2 -> addrOwner stays 0 for those cycles. It becomes 2 at the first ready=1 edge.
- reset pulsed while manager 2 is locked mid-burst -> grant=4'b0001, addrOwner=dataOwner=0 and locked=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter. It tracks address/data-phase ownership, freezes for locked
// sequences and limits consecutive wins while other managers are waiting.
module ahb_arbiter #(
  parameter int NumManagers    = 4,
  parameter int DefaultManager = 0,
  parameter int MaxHold        = 4,
  localparam int IdWidth       = $clog2(NumManagers)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NumManagers-1:0] req,
  input  logic [NumManagers-1:0] lock,
  input  logic [1:0]             trans,
  input  logic                   ready,
  output logic [NumManagers-1:0] grant,
  output logic [IdWidth-1:0]     addrOwner,
  output logic [IdWidth-1:0]     dataOwner,
  output logic                   locked
);

  localparam int HoldWidth = (MaxHold > 1) ? $clog2(MaxHold) : 1;
  localparam logic [HoldWidth-1:0] HoldMax  = HoldWidth'(MaxHold - 1);
  localparam logic [HoldWidth-1:0] HoldZero = HoldWidth'(1'b0);
  localparam logic [HoldWidth-1:0] HoldOne  = HoldWidth'(1'b1);
  localparam logic [IdWidth-1:0]   DefIdx   = IdWidth'(DefaultManager);
  localparam logic [1:0] TransIdle   = 2'd0;
  localparam logic [1:0] TransNonseq = 2'd2;

  typedef enum logic [1:0] {
    PARK   = 2'd0,
    OWNED  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic [NumManagers-1:0] onehot(input logic [IdWidth-1:0] idx);
    onehot = NumManagers'(1'b1) << idx;
  endfunction

  // First requester after cur, wrapping around; cur itself is never chosen.
  function automatic logic [IdWidth-1:0] rr_next(input logic [NumManagers-1:0] r,
                                                 input logic [IdWidth-1:0] cur);
    logic                found;
    logic [IdWidth-1:0]  idx;
    rr_next = cur;
    found   = 1'b0;
    for (int k = 1; k < NumManagers; k++) begin
      idx     = IdWidth'((int'(cur) + k) % NumManagers);
      rr_next = (r[idx] && !found) ? idx : rr_next;
      found   = found | r[idx];
    end
  endfunction

  logic [IdWidth-1:0]   grant_idx_r;
  logic [HoldWidth-1:0] hold_cnt_r;
  state_t               state_r;

  logic                 arb_point_s;
  logic                 lock_entry_s;
  logic                 others_s;
  logic [IdWidth-1:0]   next_idx_s;
  logic [HoldWidth-1:0] next_hold_s;
  state_t               next_state_s;

  // Arbitration points need a completed handover and an unlocked IDLE/NONSEQ address phase.
  always_comb begin
    arb_point_s  = ready && (grant_idx_r == addrOwner) &&
                   ((trans == TransIdle) || (trans == TransNonseq)) && !lock[addrOwner];
    lock_entry_s = ready && (state_r == OWNED) && (grant_idx_r == addrOwner) &&
                   lock[addrOwner] && (trans != TransIdle);
    others_s     = |(req & ~onehot(grant_idx_r));
  end

  // Next grant, hold count and state.
  always_comb begin
    next_idx_s   = grant_idx_r;
    next_hold_s  = hold_cnt_r;
    next_state_s = state_r;
    if (arb_point_s) begin
      if (req == {NumManagers{1'b0}}) begin
        next_idx_s   = DefIdx;
        next_hold_s  = HoldZero;
        next_state_s = PARK;
      end else if (req[grant_idx_r] && ((hold_cnt_r < HoldMax) || !others_s)) begin
        next_hold_s  = (hold_cnt_r == HoldMax) ? hold_cnt_r : hold_cnt_r + HoldOne;
        next_state_s = OWNED;
      end else begin
        next_idx_s   = rr_next(req, grant_idx_r);
        next_hold_s  = HoldZero;
        next_state_s = OWNED;
      end
    end else if (lock_entry_s) begin
      next_state_s = LOCKED;
    end else begin
      next_state_s = state_r;
    end
  end

  // State and output registers; a low ready freezes everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_idx_r <= DefIdx;
      grant       <= onehot(DefIdx);
      addrOwner   <= DefIdx;
      dataOwner   <= DefIdx;
      locked      <= 1'b0;
      hold_cnt_r  <= HoldZero;
      state_r     <= PARK;
    end else if (ready) begin
      addrOwner   <= grant_idx_r;
      dataOwner   <= addrOwner;
      locked      <= lock[grant_idx_r];
      grant_idx_r <= next_idx_s;
      grant       <= onehot(next_idx_s);
      hold_cnt_r  <= next_hold_s;
      state_r     <= next_state_s;
    end else begin
      state_r     <= state_r;
    end
  end

endmodule
